// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Inter-stage pipeline register with a valid/ready handshake and a
//             2-entry skid (main + skid), so in_ready can be a flop while the
//             stage still moves one entry per cycle. A synchronous flush
//             empties the stage and leaves a bubble that carries in_pc. A
//             saturating counter records how many valid entries flush threw
//             away.
//  Ports    : clk, reset (async, active-high)
//             in_valid / in_ready / in_data / in_pc   - upstream side
//             flush                                   - bubble insert
//             out_valid / out_ready / out_data / out_pc - downstream side
//             flush_drops                             - discarded-entry count
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
    parameter int              CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  flush_drops
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [PC_W-1:0]   r_main_pc;
    logic [DATA_W-1:0] r_skid_data;
    logic [PC_W-1:0]   r_skid_pc;
    logic [CNT_W-1:0]  r_flush_drops;

    state_t            w_state_nx;
    logic [DATA_W-1:0] w_main_data_nx;
    logic [PC_W-1:0]   w_main_pc_nx;
    logic [DATA_W-1:0] w_skid_data_nx;
    logic [PC_W-1:0]   w_skid_pc_nx;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_drop_main;
    logic              w_drop_skid;
    logic [CNT_W+1:0]  w_cnt_sum;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Entries lost to a flush: a main entry not taken this cycle, the skid
    // entry (never delivered in the same cycle) and any entry accepted now.
    assign w_drop_main = r_out_valid & ~w_out_fire;
    assign w_drop_skid = (r_state == ST_FULL);
    assign w_cnt_sum   = {2'b00, r_flush_drops}
                       + {{(CNT_W+1){1'b0}}, w_drop_main}
                       + {{(CNT_W+1){1'b0}}, w_drop_skid}
                       + {{(CNT_W+1){1'b0}}, w_in_fire};

    always_comb begin
        w_state_nx     = r_state;
        w_main_data_nx = r_main_data;
        w_main_pc_nx   = r_main_pc;
        w_skid_data_nx = r_skid_data;
        w_skid_pc_nx   = r_skid_pc;
        w_cnt_nx       = r_flush_drops;

        if (flush) begin
            w_state_nx     = ST_EMPTY;
            w_main_data_nx = '0;
            w_main_pc_nx   = in_pc;
            w_cnt_nx       = (w_cnt_sum[CNT_W+1:CNT_W] != 2'b00) ? c_cnt_max
                                                                : w_cnt_sum[CNT_W-1:0];
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_data_nx = in_data;
                        w_main_pc_nx   = in_pc;
                        w_state_nx     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_data_nx = in_data;
                        w_main_pc_nx   = in_pc;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new entry behind main.
                        w_skid_data_nx = in_data;
                        w_skid_pc_nx   = in_pc;
                        w_state_nx     = ST_FULL;
                    end else if (w_out_fire) begin
                        // Main keeps its stale contents; out_valid qualifies it.
                        w_state_nx = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_main_data_nx = r_skid_data;
                        w_main_pc_nx   = r_skid_pc;
                        w_state_nx     = ST_ONE;
                    end
                end
                default: begin
                    w_state_nx = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_EMPTY;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_main_data   <= '0;
            r_main_pc     <= RESET_PC;
            r_skid_data   <= '0;
            r_skid_pc     <= '0;
            r_flush_drops <= '0;
        end else begin
            r_state       <= w_state_nx;
            // Handshake flags are decoded from the next state so both are
            // plain flops with no combinational path from the inputs.
            r_in_ready    <= (w_state_nx != ST_FULL);
            r_out_valid   <= (w_state_nx != ST_EMPTY);
            r_main_data   <= w_main_data_nx;
            r_main_pc     <= w_main_pc_nx;
            r_skid_data   <= w_skid_data_nx;
            r_skid_pc     <= w_skid_pc_nx;
            r_flush_drops <= w_cnt_nx;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_main_data;
    assign out_pc      = r_main_pc;
    assign flush_drops = r_flush_drops;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Purpose  : Self-checking bench for pipe_stage_skid. Directed scenarios
//             followed by random traffic, all compared each cycle against a
//             queue-based reference model. A second instance with CNT_W=2
//             shares the stimulus to exercise counter saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int          DW  = 128;
    localparam int          PW  = 32;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [PW-1:0] in_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [PW-1:0] out_pc;
    logic [7:0]    flush_drops;

    logic          s_in_ready;
    logic          s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [PW-1:0] s_out_pc;
    logic [1:0]    s_flush_drops;

    pipe_stage_skid #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
        .flush_drops(flush_drops)
    );

    pipe_stage_skid #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_pc(in_pc),
        .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_pc(s_out_pc),
        .flush_drops(s_flush_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] pc;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] stale_d;
    logic [PW-1:0] stale_pc;
    int            cnt_big;
    int            cnt_small;
    int            total;
    int            bad;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        stale_d   = '0;
        stale_pc  = RPC;
        cnt_big   = 0;
        cnt_small = 0;
    endtask

    task automatic check_all(input string tag);
        logic          ev;
        logic [DW-1:0] ed;
        logic [PW-1:0] ep;
        ev = (q.size() > 0);
        ed = ev ? q[0].d  : stale_d;
        ep = ev ? q[0].pc : stale_pc;
        check({tag, ".out_valid"},   DW'(out_valid),     DW'(ev));
        check({tag, ".in_ready"},    DW'(in_ready),      DW'(q.size() < 2));
        check({tag, ".out_data"},    out_data,           ed);
        check({tag, ".out_pc"},      DW'(out_pc),        DW'(ep));
        check({tag, ".drops"},       DW'(flush_drops),   DW'(cnt_big));
        check({tag, ".drops_c2"},    DW'(s_flush_drops), DW'(cnt_small));
    endtask

    // Advance one clock edge with the inputs currently driven, update the
    // model from the handshake rules, then compare just after the edge.
    task automatic step(input string tag);
        bit   inf;
        bit   outf;
        int   drops;
        ent_t e;
        inf  = in_valid  && (q.size() < 2);
        outf = out_ready && (q.size() > 0);
        @(posedge clk);
        if (flush) begin
            drops     = q.size() - (outf ? 1 : 0) + (inf ? 1 : 0);
            q.delete();
            stale_d   = '0;
            stale_pc  = in_pc;
            cnt_big   = (cnt_big + drops > 255) ? 255 : cnt_big + drops;
            cnt_small = (cnt_small + drops > 3) ? 3 : cnt_small + drops;
        end else begin
            if (outf) begin
                e = q.pop_front();
                if (q.size() == 0) begin
                    stale_d  = e.d;
                    stale_pc = e.pc;
                end
            end
            if (inf) begin
                e.d  = in_data;
                e.pc = in_pc;
                q.push_back(e);
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] pc,
                         input logic ordy, input logic fl, input string tag);
        in_valid  = v;
        in_data   = d;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        step(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1: back-to-back stream
        drive(1'b1, 128'd1, 32'h3000, 1'b1, 1'b0, "t1a");
        check("t1.first", out_data, 128'd1);
        drive(1'b1, 128'd2, 32'h3004, 1'b1, 1'b0, "t1b");
        drive(1'b1, 128'd3, 32'h3008, 1'b1, 1'b0, "t1c");
        check("t1.third", out_data, 128'd3);
        check("t1.ready", DW'(in_ready), DW'(1'b1));
        drive(1'b0, 128'd0, 32'h0, 1'b1, 1'b0, "t1d");

        // 2: stall into FULL, then drain in order
        drive(1'b1, 128'hA, 32'h300C, 1'b0, 1'b0, "t2a");
        drive(1'b1, 128'hB, 32'h3010, 1'b0, 1'b0, "t2b");
        check("t2.full_ready", DW'(in_ready), DW'(1'b0));
        drive(1'b1, 128'hC, 32'h3014, 1'b0, 1'b0, "t2c");
        drive(1'b0, 128'h0, 32'h0, 1'b1, 1'b0, "t2d");
        check("t2.second", out_data, 128'hB);
        drive(1'b0, 128'h0, 32'h0, 1'b1, 1'b0, "t2e");

        // 3: flush while FULL
        drive(1'b1, 128'hA, 32'h3000, 1'b0, 1'b0, "t3a");
        drive(1'b1, 128'hB, 32'h3004, 1'b0, 1'b0, "t3b");
        drive(1'b0, 128'h0, 32'h3010, 1'b0, 1'b1, "t3f");
        check("t3.pc", DW'(out_pc), DW'(32'h3010));
        check("t3.drops", DW'(flush_drops), DW'(8'd2));

        // 4: flush with in_fire and out_fire in the same cycle
        drive(1'b1, 128'h11, 32'h3020, 1'b0, 1'b0, "t4a");
        drive(1'b1, 128'h22, 32'h3024, 1'b1, 1'b1, "t4f");
        check("t4.drops", DW'(flush_drops), DW'(8'd3));
        drive(1'b0, 128'h0, 32'h0, 1'b1, 1'b0, "t4b");

        // 5: saturation on the narrow counter
        async_reset("t5rst");
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(i + 5), 32'h3100, 1'b0, 1'b0, "t5push");
            drive(1'b0, 128'h0, 32'h3200, 1'b0, 1'b1, "t5flush");
        end
        check("t5.sat", DW'(s_flush_drops), DW'(2'd3));
        check("t5.wide", DW'(flush_drops), DW'(8'd4));

        // 6: async reset mid-stall in FULL, then a fresh transfer
        drive(1'b1, 128'hA, 32'h3000, 1'b0, 1'b0, "t6a");
        drive(1'b1, 128'hB, 32'h3004, 1'b0, 1'b0, "t6b");
        async_reset("t6rst");
        check("t6.pc", DW'(out_pc), DW'(RPC));
        drive(1'b1, 128'h55, 32'h3040, 1'b1, 1'b0, "t6c");
        drive(1'b0, 128'h0, 32'h0, 1'b1, 1'b0, "t6d");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0),
                  "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
